// File: rtl/usb_tx_line_encoder.sv
// usb_tx_line_encoder
//   Transmit-side USB full-speed line encoder. Packet bytes arrive from the TX
//   protocol FSM over a valid/ready handshake. Each packet goes onto D+/D- as
//   SYNC, then the payload LSB first, then EOP. Bit stuffing and NRZI are
//   applied along the way. The idle line state is J.
//
// Ports
//   clk         system clock
//   n_rst       asynchronous active-low reset
//   tx_start    1-cycle pulse that starts a packet (honoured only in IDLE)
//   tx_data     payload byte, sent LSB first
//   tx_valid    tx_data / tx_last are valid
//   tx_last     marks the final byte of the packet
//   tx_ready    a byte is accepted on any cycle where tx_valid && tx_ready
//   dplus_out   D+ line drive (registered)
//   dminus_out  D- line drive (registered)
//   tx_busy     high from the cycle after tx_start until the EOP J bit completes
//   tx_err      1-cycle pulse when the holding register underruns
module usb_tx_line_encoder #(
    parameter int CLKS_PER_BIT = 8,
    parameter int STUFF_LEN    = 6
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       dplus_out,
    output logic       dminus_out,
    output logic       tx_busy,
    output logic       tx_err
);

    localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int ONES_W = $clog2(STUFF_LEN + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(STUFF_LEN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_STUFF,
        ST_EOP_SE0,
        ST_EOP_J
    } state_t;

    state_t            state_q;
    state_t            resume_q;     // state interrupted by a stuffed bit
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        bit_idx_q;    // index of the bit currently on the line
    logic [7:0]        shift_q;      // byte currently being transmitted
    logic              cur_last_q;   // shift_q holds the final byte
    logic [7:0]        hold_q;
    logic              hold_full_q;
    logic              hold_last_q;
    logic              last_acc_q;   // a tx_last byte was accepted this packet
    logic [ONES_W-1:0] ones_q;
    logic              dp_q;
    logic              dm_q;
    logic              busy_q;
    logic              err_q;
    logic              rdy_en_q;     // keeps tx_ready low while in reset

    logic bit_end;
    logic accept;

    // What follows the current bit, ignoring stuffing
    state_t     nb_st;
    state_t     base_st;
    logic [2:0] nb_idx;
    logic       nb_bit;
    logic       nb_load;
    logic       nb_eop;
    logic       nb_err;

    assign bit_end  = (cnt_q == CNT_MAX);
    assign tx_ready = rdy_en_q && !hold_full_q && !last_acc_q &&
                      (state_q != ST_EOP_SE0) && (state_q != ST_EOP_J);
    assign accept   = tx_valid && tx_ready;

    // A stuffed bit resumes at the point it interrupted, so after a stuffed
    // bit the decision is made as if the interrupted bit had just ended.
    always_comb begin
        base_st = (state_q == ST_STUFF) ? resume_q : state_q;
        nb_st   = base_st;
        nb_idx  = bit_idx_q + 3'd1;
        nb_bit  = 1'b0;
        nb_load = 1'b0;
        nb_eop  = 1'b0;
        nb_err  = 1'b0;
        if (bit_idx_q != 3'd7) begin
            if (base_st == ST_SYNC) begin
                // SYNC is 8'h80 LSB first: only the final bit is a 1
                nb_bit = (nb_idx == 3'd7);
            end else begin
                nb_bit = shift_q[nb_idx];
            end
        end else if ((base_st == ST_DATA) && cur_last_q) begin
            nb_eop = 1'b1;
        end else if (hold_full_q) begin
            nb_st   = ST_DATA;
            nb_idx  = 3'd0;
            nb_load = 1'b1;
            nb_bit  = hold_q[0];
        end else begin
            nb_eop = 1'b1;
            nb_err = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            resume_q    <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            cur_last_q  <= 1'b0;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            hold_last_q <= 1'b0;
            last_acc_q  <= 1'b0;
            ones_q      <= '0;
            dp_q        <= 1'b1;
            dm_q        <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            rdy_en_q    <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            err_q    <= 1'b0;

            if (accept) begin
                hold_q      <= tx_data;
                hold_last_q <= tx_last;
                hold_full_q <= 1'b1;
                if (tx_last) begin
                    last_acc_q <= 1'b1;
                end
            end

            if (state_q != ST_IDLE) begin
                cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (tx_start) begin
                        // First SYNC bit is a 0: J -> K
                        state_q   <= ST_SYNC;
                        bit_idx_q <= 3'd0;
                        cnt_q     <= '0;
                        ones_q    <= '0;
                        busy_q    <= 1'b1;
                        dp_q      <= 1'b0;
                        dm_q      <= 1'b1;
                    end
                end

                ST_SYNC, ST_DATA, ST_STUFF: begin
                    if (bit_end) begin
                        if ((state_q != ST_STUFF) && (ones_q == ONES_MAX)) begin
                            state_q  <= ST_STUFF;
                            resume_q <= state_q;
                            ones_q   <= '0;
                            dp_q     <= ~dp_q;
                            dm_q     <= dp_q;
                        end else if (nb_eop) begin
                            state_q   <= ST_EOP_SE0;
                            bit_idx_q <= 3'd0;
                            ones_q    <= '0;
                            dp_q      <= 1'b0;
                            dm_q      <= 1'b0;
                            err_q     <= nb_err;
                            if (nb_err) begin
                                // Aborted packet: drop anything caught in the holding register
                                hold_full_q <= 1'b0;
                                hold_last_q <= 1'b0;
                            end
                        end else begin
                            state_q   <= nb_st;
                            bit_idx_q <= nb_idx;
                            if (nb_load) begin
                                shift_q     <= hold_q;
                                cur_last_q  <= hold_last_q;
                                hold_full_q <= 1'b0;
                            end
                            // NRZI: a 1 holds the level, a 0 toggles J<->K
                            if (nb_bit) begin
                                ones_q <= ones_q + 1'b1;
                            end else begin
                                ones_q <= '0;
                                dp_q   <= ~dp_q;
                                dm_q   <= dp_q;
                            end
                        end
                    end
                end

                ST_EOP_SE0: begin
                    if (bit_end) begin
                        if (bit_idx_q == 3'd1) begin
                            state_q <= ST_EOP_J;
                            dp_q    <= 1'b1;
                            dm_q    <= 1'b0;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end

                ST_EOP_J: begin
                    if (bit_end) begin
                        state_q    <= ST_IDLE;
                        busy_q     <= 1'b0;
                        last_acc_q <= 1'b0;
                        cur_last_q <= 1'b0;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dplus_out  = dp_q;
    assign dminus_out = dm_q;
    assign tx_busy    = busy_q;
    assign tx_err     = err_q;

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
module tb_usb_tx_line_encoder;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_ready;
    logic       dplus_out;
    logic       dminus_out;
    logic       tx_busy;
    logic       tx_err;

    int total = 0;
    int bad = 0;
    int err_pulses = 0;
    bit mon_skip = 1'b0;

    // Expected line symbols per bit period: J=10, K=01, SE0=00, 11 = busy low
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    usb_tx_line_encoder #(
        .CLKS_PER_BIT(CPB),
        .STUFF_LEN(6)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_last(tx_last),
        .tx_ready(tx_ready),
        .dplus_out(dplus_out),
        .dminus_out(dminus_out),
        .tx_busy(tx_busy),
        .tx_err(tx_err)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic push_str(input string s);
        byte c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            case (c)
                "J":     exp_q.push_back(2'b10);
                "K":     exp_q.push_back(2'b01);
                "0":     exp_q.push_back(2'b00);
                default: exp_q.push_back(2'b11);
            endcase
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int guard;
        guard = 0;
        @(posedge clk); #1;
        tx_data  = d;
        tx_last  = l;
        tx_valid = 1'b1;
        while (!tx_ready && guard < 400) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 400) begin
            total++;
            bad++;
            $display("FAIL accept timeout: byte %h never accepted", d);
        end
        @(posedge clk); #1;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || tx_busy) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (guard >= 2000) begin
            bad++;
            $display("FAIL %s drain: got %0d pending symbols want 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    // Monitor: checks the line at the first and last cycle of every bit period
    initial begin : monitor
        int off;
        int bitn;
        bit in_pkt;
        logic [1:0] s0;
        logic [1:0] s1;
        logic [1:0] sn;
        logic [1:0] e;
        off = 0;
        bitn = 0;
        in_pkt = 1'b0;
        s0 = 2'b00;
        s1 = 2'b00;
        forever begin
            @(negedge clk);
            if (tx_err) err_pulses++;
            sn = tx_busy ? {dplus_out, dminus_out} : 2'b11;
            if (!n_rst) begin
                in_pkt = 1'b0;
            end else if (!in_pkt) begin
                if (tx_busy && !mon_skip) begin
                    in_pkt = 1'b1;
                    off = 0;
                    bitn = 0;
                    s0 = sn;
                end
            end else begin
                off = (off + 1) % CPB;
                if (off == 0) s0 = sn;
                if (off == CPB - 1) begin
                    s1 = sn;
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL line bit%0d: got %b/%b want nothing", bitn, s0, s1);
                        in_pkt = 1'b0;
                    end else begin
                        e = exp_q.pop_front();
                        if (s0 !== e || s1 !== e) begin
                            bad++;
                            $display("FAIL line bit%0d: got %b/%b want %b", bitn, s0, s1, e);
                        end
                        if (e == 2'b11 || s1 == 2'b11) in_pkt = 1'b0;
                    end
                    bitn++;
                end
            end
        end
    end

    initial begin : stimulus
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst dplus", int'(dplus_out), 1);
        check("rst dminus", int'(dminus_out), 0);
        check("rst busy", int'(tx_busy), 0);
        check("rst err", int'(tx_err), 0);
        check("rst ready", int'(tx_ready), 0);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle ready", int'(tx_ready), 1);

        // 8'h00 last: alternating line
        send_byte(8'h00, 1'b1);
        @(negedge clk);
        check("ready after last preload", int'(tx_ready), 0);
        push_str("KJKJKJKK");
        push_str("JKJKJKJK");
        push_str("00J.");
        pulse_start();
        wait_drain("t00");
        check("t00 err", err_pulses, 0);
        check("t00 ready in idle", int'(tx_ready), 1);

        // 8'hFF last: stuffed bit after the fifth payload 1
        send_byte(8'hFF, 1'b1);
        push_str("KJKJKJKK");
        push_str("KKKKK");
        push_str("J");
        push_str("JJJ");
        push_str("00J.");
        pulse_start();
        wait_drain("tFF");

        // 8'hA5 then 8'h3C back-to-back
        send_byte(8'hA5, 1'b0);
        push_str("KJKJKJKK");
        push_str("KJJKJJKK");
        push_str("JKKKKKJK");
        push_str("00J.");
        pulse_start();
        send_byte(8'h3C, 1'b1);
        @(negedge clk);
        check("ready after 3C", int'(tx_ready), 0);
        wait_drain("tA53C");
        check("tA53C err", err_pulses, 0);

        // Underrun: one byte, no tx_last, nothing follows
        send_byte(8'h0F, 1'b0);
        push_str("KJKJKJKK");
        push_str("KKKKJKJK");
        push_str("00J.");
        pulse_start();
        wait_drain("tunder");
        check("underrun err pulses", err_pulses, 1);
        check("underrun ready in idle", int'(tx_ready), 1);

        // 8'hFC last: stuffed bit after the final payload bit, before EOP
        send_byte(8'hFC, 1'b1);
        push_str("KJKJKJKK");
        push_str("JKKKKKKK");
        push_str("J");
        push_str("00J.");
        pulse_start();
        wait_drain("tFC");

        // tx_start during DATA is ignored
        send_byte(8'h3C, 1'b1);
        push_str("KJKJKJKK");
        push_str("JKKKKKJK");
        push_str("00J.");
        pulse_start();
        repeat (12 * CPB) @(posedge clk);
        pulse_start();
        wait_drain("tstart_ign");
        check("start ignored err", err_pulses, 1);

        // Reset mid-payload
        send_byte(8'hFF, 1'b1);
        mon_skip = 1'b1;
        pulse_start();
        repeat (12 * CPB) @(posedge clk);
        #3;
        n_rst = 1'b0;
        #1;
        check("midrst dplus", int'(dplus_out), 1);
        check("midrst dminus", int'(dminus_out), 0);
        check("midrst busy", int'(tx_busy), 0);
        check("midrst ready", int'(tx_ready), 0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        mon_skip = 1'b0;
        repeat (3) @(negedge clk);
        check("post rst ready", int'(tx_ready), 1);
        check("post rst busy", int'(tx_busy), 0);

        // Fresh packet after reset
        send_byte(8'h01, 1'b1);
        push_str("KJKJKJKK");
        push_str("KJKJKJKJ");
        push_str("00J.");
        pulse_start();
        wait_drain("tpostrst");
        check("final err pulses", err_pulses, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
